mesh_rd_data_egress: RTL and testbench

- Edge-of-mesh read-data receiver; one instance per mesh edge (west by default). It sinks the registered `*_data_out_vld`/pld lanes leaving the SRAM-group xy mesh.
- Per-channel FIFOs buffer the returned data, and it presents a valid/ready stream to the requester.
- The mesh has no backpressure, so the block also owns a per-channel credit counter. The read issuer must take a credit before launching a read into the mesh.

---
 rtl/mesh_rd_data_egress_if.sv | 29 ++
 rtl/mesh_rd_data_egress.sv | 154 +++++++++++++++
 tb/tb_mesh_rd_data_egress.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mesh_rd_data_egress_if.sv
// Edge-of-mesh read-data bundle: mesh lanes in, requester stream out,
// issuer credit handshake and sticky error flags.
interface mesh_rd_data_egress_if #(
  parameter int CH_NUM = 8,
  parameter int PLD_W  = 128
);
  logic [CH_NUM-1:0]       in_vld;
  logic [CH_NUM*PLD_W-1:0] in_pld;
  logic [CH_NUM-1:0]       cred_take;
  logic [CH_NUM-1:0]       cred_avail;
  logic [CH_NUM-1:0]       out_vld;
  logic [CH_NUM-1:0]       out_rdy;
  logic [CH_NUM*PLD_W-1:0] out_pld;
  logic [CH_NUM-1:0]       ovf_err;
  logic [CH_NUM-1:0]       dir_err;
  logic [CH_NUM-1:0]       cred_err;

  // master: mesh edge + issuer + requester side
  modport master (
    output in_vld, in_pld, cred_take, out_rdy,
    input  cred_avail, out_vld, out_pld, ovf_err, dir_err, cred_err
  );

  // slave: the egress block
  modport slave (
    input  in_vld, in_pld, cred_take, out_rdy,
    output cred_avail, out_vld, out_pld, ovf_err, dir_err, cred_err
  );
endinterface

// File: rtl/mesh_rd_data_egress.sv
// Edge-of-mesh read-data receiver. Each lane owns an FWFT FIFO plus a
// credit counter; the mesh cannot stall, so the issuer must hold a credit
// (a reserved FIFO slot) before launching a read.

// One lane: FIFO, credit FSM, sticky error flags.
module mesh_rd_egress_lane #(
  parameter int PLD_W      = 128,
  parameter int DIR_LSB    = 0,
  parameter int DIR_ID     = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_vld,
  input  logic [PLD_W-1:0] in_pld,
  input  logic             cred_take,
  output logic             cred_avail,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [PLD_W-1:0] out_pld,
  output logic             ovf_err,
  output logic             dir_err,
  output logic             cred_err
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {AVAIL, EXHAUSTED} cst_t;
  typedef struct packed {
    logic ovf;
    logic dir;
    logic cred;
  } err_t;

  logic [PLD_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    occ, cnt;
  cst_t             cst;
  err_t             err;

  logic dir_ok, full, pop, push, cnt_zero;

  assign dir_ok   = in_pld[DIR_LSB +: 2] == 2'(DIR_ID);
  assign full     = occ == CW'(FIFO_DEPTH);
  assign pop      = out_vld & out_rdy;
  // a full FIFO still accepts when the head leaves in the same cycle
  assign push     = in_vld & dir_ok & (~full | pop);
  assign cnt_zero = cnt == '0;

  assign out_vld    = occ != '0;
  assign out_pld    = mem[rd_ptr];
  assign cred_avail = cst == AVAIL;
  assign ovf_err    = err.ovf;
  assign dir_err    = err.dir;
  assign cred_err   = err.cred;

  // FIFO storage, pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < FIFO_DEPTH; k++) mem[k] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_pld;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      occ <= occ + CW'(1);
      else if (pop && !push) occ <= occ - CW'(1);
    end
  end

  // Credit FSM: count plus AVAIL/EXHAUSTED state; a take at zero is only
  // honoured when a pop frees a slot in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cst <= AVAIL;
      cnt <= CW'(FIFO_DEPTH);
    end else begin
      if (pop && !cred_take)                   cnt <= cnt + CW'(1);
      else if (cred_take && !pop && !cnt_zero) cnt <= cnt - CW'(1);
      case (cst)
        AVAIL:     if (cred_take && !pop && cnt == CW'(1)) cst <= EXHAUSTED;
        EXHAUSTED: if (pop && !cred_take)                  cst <= AVAIL;
        default:   cst <= AVAIL;
      endcase
    end
  end

  // Sticky error flags, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= '0;
    end else begin
      if (in_vld && dir_ok && full && !pop) err.ovf  <= 1'b1;
      if (in_vld && !dir_ok)                err.dir  <= 1'b1;
      if (cred_take && !pop && cnt_zero)    err.cred <= 1'b1;
    end
  end

  a_pld_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (out_vld && !out_rdy) |=> $stable(out_pld));
  a_cnt_max: assert property (@(posedge clk) disable iff (!rst_n)
    !(pop && !cred_take && cnt == CW'(FIFO_DEPTH)));
  a_slot_sum: assert property (@(posedge clk) disable iff (!rst_n)
    ({1'b0, occ} + {1'b0, cnt}) <= (CW+1)'(FIFO_DEPTH));
endmodule

module mesh_rd_data_egress #(
  parameter int CH_NUM     = 8,
  parameter int PLD_W      = 128,
  parameter int DIR_LSB    = 0,
  parameter int DIR_ID     = 0,
  parameter int FIFO_DEPTH = 4
) (
  input logic                    clk,
  input logic                    rst_n,
  mesh_rd_data_egress_if.slave   bus
);
  logic [CH_NUM-1:0]            cred_avail, out_vld, ovf_err, dir_err, cred_err;
  logic [CH_NUM-1:0][PLD_W-1:0] out_pld;

  assign bus.cred_avail = cred_avail;
  assign bus.out_vld    = out_vld;
  assign bus.out_pld    = out_pld;
  assign bus.ovf_err    = ovf_err;
  assign bus.dir_err    = dir_err;
  assign bus.cred_err   = cred_err;

  // Lanes are fully independent: no arbitration between them
  for (genvar i = 0; i < CH_NUM; i++) begin : g_lane
    mesh_rd_egress_lane #(
      .PLD_W      (PLD_W),
      .DIR_LSB    (DIR_LSB),
      .DIR_ID     (DIR_ID),
      .FIFO_DEPTH (FIFO_DEPTH)
    ) u_lane (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_vld     (bus.in_vld[i]),
      .in_pld     (bus.in_pld[i*PLD_W +: PLD_W]),
      .cred_take  (bus.cred_take[i]),
      .cred_avail (cred_avail[i]),
      .out_vld    (out_vld[i]),
      .out_rdy    (bus.out_rdy[i]),
      .out_pld    (out_pld[i]),
      .ovf_err    (ovf_err[i]),
      .dir_err    (dir_err[i]),
      .cred_err   (cred_err[i])
    );
  end
endmodule

// File: tb/tb_mesh_rd_data_egress.sv
// Bench for mesh_rd_data_egress: per-lane scoreboard of expected heads,
// credit counts and sticky flags, plus directed boundary scenarios.
module tb_mesh_rd_data_egress;
  localparam int CH    = 8;
  localparam int W     = 128;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mesh_rd_data_egress_if #(.CH_NUM(CH), .PLD_W(W)) bus();

  mesh_rd_data_egress #(
    .CH_NUM(CH), .PLD_W(W), .DIR_LSB(0), .DIR_ID(0), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_run  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // scoreboard state
  logic [W-1:0] exp_q [CH][$];
  int           m_cnt  [CH];
  bit           m_oerr [CH];
  bit           m_derr [CH];
  bit           m_cerr [CH];
  bit           mon_en = 1'b0;

  function automatic void mdl_reset();
    for (int i = 0; i < CH; i++) begin
      exp_q[i].delete();
      m_cnt[i]  = DEPTH;
      m_oerr[i] = 1'b0;
      m_derr[i] = 1'b0;
      m_cerr[i] = 1'b0;
    end
  endfunction

  // Compare DUT state against the model, then advance the model by what
  // the coming posedge will see
  always @(negedge clk) begin : mon
    logic [W-1:0] pld;
    bit           vld_e, pop, tk;
    int           sz;
    if (mon_en) begin
      for (int i = 0; i < CH; i++) begin
        sz    = exp_q[i].size();
        vld_e = sz != 0;
        chk($sformatf("vld%0d", i), W'(bus.out_vld[i]), W'(vld_e));
        if (vld_e) chk($sformatf("pld%0d", i), bus.out_pld[i*W +: W], exp_q[i][0]);
        chk($sformatf("cav%0d", i), W'(bus.cred_avail[i]), W'(m_cnt[i] != 0));
        chk($sformatf("ovf%0d", i), W'(bus.ovf_err[i]), W'(m_oerr[i]));
        chk($sformatf("dir%0d", i), W'(bus.dir_err[i]), W'(m_derr[i]));
        chk($sformatf("cer%0d", i), W'(bus.cred_err[i]), W'(m_cerr[i]));
        pop = vld_e && bus.out_rdy[i];
        tk  = bus.cred_take[i];
        pld = bus.in_pld[i*W +: W];
        if (pop) void'(exp_q[i].pop_front());
        if (bus.in_vld[i]) begin
          if (pld[1:0] != 2'b00)      m_derr[i] = 1'b1;
          else if (sz < DEPTH || pop) exp_q[i].push_back(pld);
          else                        m_oerr[i] = 1'b1;
        end
        if (tk && !pop) begin
          if (m_cnt[i] == 0) m_cerr[i] = 1'b1;
          else               m_cnt[i]--;
        end else if (pop && !tk) begin
          m_cnt[i]++;
        end
      end
    end
  end

  function automatic logic [W-1:0] mk_pld(input logic [1:0] dir);
    logic [W-1:0] p;
    p = {$urandom(), $urandom(), $urandom(), $urandom()};
    p[1:0] = dir;
    return p;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_vld    = '0;
    bus.in_pld    = '0;
    bus.cred_take = '0;
    bus.out_rdy   = '0;
  endtask

  task automatic drive(input int ln, input logic v, input logic tk, input logic [W-1:0] p);
    bus.in_vld[ln]      = v;
    bus.cred_take[ln]   = tk;
    bus.in_pld[ln*W +: W] = p;
  endtask

  task automatic take_n(input int ln, input int n);
    for (int k = 0; k < n; k++) begin
      bus.cred_take[ln] = 1'b1;
      step();
    end
    bus.cred_take[ln] = 1'b0;
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    idle();
    rst_n = 1'b0;
    repeat (2) step();
    chk("rst_cav", W'(bus.cred_avail), W'(8'hFF));
    chk("rst_vld", W'(bus.out_vld), '0);
    chk("rst_pld", bus.out_pld[W-1:0], '0);
    chk("rst_err", W'({bus.ovf_err, bus.dir_err, bus.cred_err}), '0);
    mdl_reset();
    rst_n  = 1'b1;
    mon_en = 1'b1;
  endtask

  logic [W-1:0] p [6];

  initial begin
    idle();
    // idle after reset, then exhaust lane 3
    do_reset();
    step();
    chk("idle_cav", W'(bus.cred_avail), W'(8'hFF));
    chk("idle_vld", W'(bus.out_vld), '0);
    take_n(3, 4);
    chk("l3_exh", W'(bus.cred_avail), W'(8'hF7));

    // lane 0: three beats held, then drained in order
    do_reset();
    for (int k = 0; k < 3; k++) p[k] = mk_pld(2'b00);
    for (int k = 0; k < 3; k++) begin
      drive(0, 1'b1, 1'b1, p[k]);
      step();
      if (k == 0) begin
        chk("l0_lat_vld", W'(bus.out_vld[0]), W'(1'b1));
        chk("l0_lat_pld", bus.out_pld[0 +: W], p[0]);
      end
    end
    drive(0, 1'b0, 1'b0, '0);
    repeat (2) step();
    chk("l0_hold", bus.out_pld[0 +: W], p[0]);
    bus.out_rdy[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("l0_ord%0d", k), bus.out_pld[0 +: W], p[k]);
      step();
    end
    bus.out_rdy[0] = 1'b0;
    chk("l0_empty", W'(bus.out_vld[0]), '0);
    take_n(0, 3);
    chk("l0_cred3", W'(bus.cred_avail[0]), W'(1'b1));
    take_n(0, 1);
    chk("l0_cred4", W'(bus.cred_avail[0]), '0);

    // lane 5: full, pop+push when full, then overflow drop
    do_reset();
    for (int k = 0; k < 6; k++) p[k] = mk_pld(2'b00);
    for (int k = 0; k < 4; k++) begin
      drive(5, 1'b1, 1'b1, p[k]);
      step();
    end
    bus.out_rdy[5] = 1'b1;
    drive(5, 1'b1, 1'b1, p[4]);
    step();
    bus.out_rdy[5] = 1'b0;
    drive(5, 1'b0, 1'b0, '0);
    chk("l5_no_ovf", W'(bus.ovf_err[5]), '0);
    chk("l5_head", bus.out_pld[5*W +: W], p[1]);
    drive(5, 1'b1, 1'b0, p[5]);
    step();
    drive(5, 1'b0, 1'b0, '0);
    chk("l5_ovf", W'(bus.ovf_err[5]), W'(1'b1));
    bus.out_rdy[5] = 1'b1;
    repeat (6) step();
    bus.out_rdy[5] = 1'b0;
    chk("l5_drained", W'(bus.out_vld[5]), '0);

    // lane 2: wrong direction is dropped and costs no credit
    do_reset();
    drive(2, 1'b1, 1'b0, mk_pld(2'b11));
    step();
    drive(2, 1'b0, 1'b0, '0);
    step();
    chk("l2_dir", W'(bus.dir_err[2]), W'(1'b1));
    chk("l2_vld", W'(bus.out_vld[2]), '0);
    take_n(2, 3);
    chk("l2_cred3", W'(bus.cred_avail[2]), W'(1'b1));
    take_n(2, 1);
    chk("l2_cred4", W'(bus.cred_avail[2]), '0);

    // lane 7: take at zero without and with a pop
    do_reset();
    drive(7, 1'b1, 1'b1, mk_pld(2'b00));
    step();
    drive(7, 1'b0, 1'b0, '0);
    take_n(7, 3);
    chk("l7_zero", W'(bus.cred_avail[7]), '0);
    chk("l7_no_err", W'(bus.cred_err[7]), '0);
    take_n(7, 1);
    chk("l7_cerr", W'(bus.cred_err[7]), W'(1'b1));
    chk("l7_cnt0", W'(bus.cred_avail[7]), '0);
    bus.out_rdy[7]   = 1'b1;
    bus.cred_take[7] = 1'b1;
    step();
    idle();
    chk("l7_pop_take", W'(bus.cred_avail[7]), '0);
    chk("l7_popped", W'(bus.out_vld[7]), '0);

    // all lanes streaming, random ready, then reset mid-burst
    do_reset();
    for (int c = 0; c < 200; c++) begin
      for (int i = 0; i < CH; i++) begin
        bus.out_rdy[i] = 1'($urandom_range(0, 1));
        if (m_cnt[i] > 0 && $urandom_range(0, 1) == 1) drive(i, 1'b1, 1'b1, mk_pld(2'b00));
        else                                           drive(i, 1'b0, 1'b0, '0);
      end
      step();
    end
    #1;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    chk("mid_vld", W'(bus.out_vld), '0);
    chk("mid_pld", bus.out_pld[W-1:0], '0);
    chk("mid_cav", W'(bus.cred_avail), W'(8'hFF));
    chk("mid_err", W'({bus.ovf_err, bus.dir_err, bus.cred_err}), '0);
    idle();
    mdl_reset();
    step();
    rst_n  = 1'b1;
    mon_en = 1'b1;
    repeat (3) step();
    chk("post_cav", W'(bus.cred_avail), W'(8'hFF));

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #100000;
    n_fail++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $fatal(1, "watchdog");
  end
endmodule
